// File: rtl/load_mac_unit_if.sv
// Command/status bundle for load_mac_unit: the nibble-load/multiply command
// channel plus the multiply status and accumulator outputs.
interface load_mac_unit_if #(
    parameter int W     = 8,
    parameter int ACC_W = 2*W + 4
);
    localparam int IDX_W = (W/4 > 1) ? $clog2(W/4) : 1;

    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [IDX_W-1:0] in_idx;
    logic [3:0]       in_nib;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    modport master (
        output ena, in_valid, in_op, in_idx, in_nib,
        input  in_ready, busy, done, acc, ovf
    );

    modport slave (
        input  ena, in_valid, in_op, in_idx, in_nib,
        output in_ready, busy, done, acc, ovf
    );
endinterface

// File: rtl/load_mac_unit.sv
// Nibble-loaded operand registers feeding a sequential shift-add multiplier
// that either replaces (MUL) or adds into (MAC) an unsigned accumulator.
module load_mac_unit #(
    parameter int W     = 8,
    parameter int ACC_W = 2*W + 4
) (
    input  logic          clk,
    input  logic          rst_n,
    load_mac_unit_if.slave bus
);
    localparam int IDX_W = (W/4 > 1) ? $clog2(W/4) : 1;
    localparam int CNT_W = $clog2(W);

    localparam logic [2:0] OP_LD_IN  = 3'b000;
    localparam logic [2:0] OP_LD_WGT = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_MAC    = 3'b011;
    localparam logic [2:0] OP_CLR    = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     in_r, wgt_r;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   prod, prod_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_mac;
    logic             last;
    logic             accept;
    logic [ACC_W:0]   sum;

    assign bus.in_ready = (state == IDLE) && bus.ena;
    assign bus.busy     = (state == MUL);
    assign bus.done     = (state == DONE);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        prod_nxt = prod + (mplier[0] ? mcand : '0);
        last     = (cnt == CNT_W'(W-1));
        sum      = {1'b0, bus.acc} + (ACC_W+1)'(prod_nxt);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && (bus.in_op == OP_MUL || bus.in_op == OP_MAC))
                      state_nxt = MUL;
            MUL:  if (bus.ena && last) state_nxt = DONE;
            DONE: if (bus.ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state <= IDLE;
        else if (bus.ena)  state <= state_nxt;
    end

    // ena gates every register; a stalled multiply simply resumes where it held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r    <= '0;
            wgt_r   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            cnt     <= '0;
            is_mac  <= 1'b0;
            bus.acc <= '0;
            bus.ovf <= 1'b0;
        end else if (bus.ena) begin
            case (state)
                IDLE: if (accept) begin
                    case (bus.in_op)
                        OP_LD_IN: begin
                            // Out-of-range indices match no nibble and are dropped.
                            for (int i = 0; i < W/4; i++)
                                if (bus.in_idx == IDX_W'(i)) in_r[4*i +: 4] <= bus.in_nib;
                        end
                        OP_LD_WGT: begin
                            for (int i = 0; i < W/4; i++)
                                if (bus.in_idx == IDX_W'(i)) wgt_r[4*i +: 4] <= bus.in_nib;
                        end
                        OP_MUL, OP_MAC: begin
                            mcand  <= {{W{1'b0}}, in_r};
                            mplier <= wgt_r;
                            prod   <= '0;
                            cnt    <= '0;
                            is_mac <= bus.in_op[0];
                        end
                        OP_CLR: begin
                            bus.acc <= '0;
                            bus.ovf <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        if (is_mac) begin
                            bus.acc <= sum[ACC_W-1:0];
                            bus.ovf <= bus.ovf | sum[ACC_W];
                        end else begin
                            bus.acc <= ACC_W'(prod_nxt);
                            bus.ovf <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_mac_unit.sv
// Directed bench for load_mac_unit (W=8, ACC_W=20) plus a W=12 instance for
// out-of-range nibble indices.
module tb_load_mac_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    load_mac_unit_if #(.W(8),  .ACC_W(20)) bus ();
    load_mac_unit_if #(.W(12), .ACC_W(28)) bus12 ();

    load_mac_unit #(.W(8),  .ACC_W(20)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    load_mac_unit #(.W(12), .ACC_W(28)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [0:0] idx, input logic [3:0] nib);
        bit ok = 0;
        bus.in_op = op; bus.in_idx = idx; bus.in_nib = nib; bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin ok = 1; break; end
            tick();
        end
        if (ok) tick();
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout op=%0d in_ready stayed 0, required 1", op);
        end
    endtask

    task automatic wait_done(output int lat, output int bcyc);
        lat = -1; bcyc = 0;
        for (int e = 0; e < 100; e++) begin
            if (bus.done) begin lat = e; break; end
            if (bus.busy) bcyc++;
            tick();
        end
    endtask

    task automatic run(input logic [2:0] op, output int lat, output int bcyc);
        send(op, 1'b0, 4'h0);
        wait_done(lat, bcyc);
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
        send(3'b000, 1'b0, a[3:0]); send(3'b000, 1'b1, a[7:4]);
        send(3'b001, 1'b0, b[3:0]); send(3'b001, 1'b1, b[7:4]);
    endtask

    task automatic test_reset();
        bus.ena = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_idx = '0; bus.in_nib = '0;
        bus12.ena = 1'b0; bus12.in_valid = 1'b0; bus12.in_op = '0; bus12.in_idx = '0; bus12.in_nib = '0;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.acc !== 20'h0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b ovf=%b acc=%h rdy=%b, required all 0",
                     bus.busy, bus.done, bus.ovf, bus.acc, bus.in_ready);
        end
        rst_n = 1'b1; bus.ena = 1'b1; bus12.ena = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_mul();
        int lat, bcyc;
        set_ops(8'hA5, 8'h3C);
        run(3'b010, lat, bcyc);
        checks++;
        if (lat !== 8 || bcyc !== 8) begin
            failures++; $display("FAIL mul_latency lat=%0d busy=%0d, required 8/8", lat, bcyc);
        end
        checks++;
        if (bus.acc !== 20'h026AC || bus.ovf !== 1'b0) begin
            failures++; $display("FAIL mul_result acc=%h ovf=%b, required 026ac/0", bus.acc, bus.ovf);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL mul_done_pulse done=%b rdy=%b, required 0/1", bus.done, bus.in_ready);
        end
    endtask

    task automatic test_clear_noop();
        send(3'b101, 1'b0, 4'h0);
        checks++;
        if (bus.acc !== 20'h026AC || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL noop acc=%h rdy=%b busy=%b, required 026ac/1/0", bus.acc, bus.in_ready, bus.busy);
        end
        send(3'b100, 1'b0, 4'h0);
        checks++;
        if (bus.acc !== 20'h0 || bus.ovf !== 1'b0) begin
            failures++; $display("FAIL clear acc=%h ovf=%b, required 0/0", bus.acc, bus.ovf);
        end
    endtask

    task automatic test_mac_overflow();
        int lat, bcyc;
        int bad = 0;
        set_ops(8'hFF, 8'hFF);
        send(3'b100, 1'b0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            run(3'b011, lat, bcyc);
            if (lat != 8) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL mac_latency bad_runs=%0d, required 0", bad);
        end
        checks++;
        if (bus.acc !== 20'hFE010 || bus.ovf !== 1'b0) begin
            failures++; $display("FAIL mac16 acc=%h ovf=%b, required fe010/0", bus.acc, bus.ovf);
        end
        run(3'b011, lat, bcyc);
        checks++;
        if (bus.acc !== 20'h0DE11 || bus.ovf !== 1'b1) begin
            failures++; $display("FAIL mac17 acc=%h ovf=%b, required 0de11/1", bus.acc, bus.ovf);
        end
        run(3'b010, lat, bcyc);
        checks++;
        if (bus.acc !== 20'h0FE01 || bus.ovf !== 1'b0) begin
            failures++; $display("FAIL mul_clears_ovf acc=%h ovf=%b, required 0fe01/0", bus.acc, bus.ovf);
        end
    endtask

    task automatic test_ena_stall();
        int lat = -1;
        set_ops(8'hA5, 8'h3C);
        send(3'b010, 1'b0, 4'h0);
        for (int e = 0; e < 100; e++) begin
            if (bus.done) begin lat = e; break; end
            if (e == 2) bus.ena = 1'b0;
            if (e == 5) bus.ena = 1'b1;
            tick();
        end
        bus.ena = 1'b1;
        checks++;
        if (lat !== 11) begin
            failures++; $display("FAIL stall_latency lat=%0d, required 11", lat);
        end
        checks++;
        if (bus.acc !== 20'h026AC) begin
            failures++; $display("FAIL stall_result acc=%h, required 026ac", bus.acc);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat, bcyc;
        bit seen = 0;
        send(3'b010, 1'b0, 4'h0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.acc !== 20'h0 || dut.in_r !== 8'h00) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b acc=%h in_r=%h, required 0/0/0/0",
                     bus.busy, bus.done, bus.acc, dut.in_r);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) seen = 1;
            tick();
        end
        checks++;
        if (seen || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL abort_no_done seen=%b rdy=%b, required 0/1", seen, bus.in_ready);
        end
        send(3'b000, 1'b0, 4'h2);
        send(3'b001, 1'b0, 4'h5);
        run(3'b010, lat, bcyc);
        checks++;
        if (lat !== 8 || bus.acc !== 20'h0000A) begin
            failures++; $display("FAIL abort_recover lat=%0d acc=%h, required 8/0000a", lat, bus.acc);
        end
    endtask

    task automatic test_refuse_load();
        int lat, bcyc;
        send(3'b010, 1'b0, 4'h0);
        bus.in_op = 3'b000; bus.in_idx = 1'b0; bus.in_nib = 4'hF; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL busy_ready got %b, required 0", bus.in_ready);
        end
        repeat (3) tick();
        bus.in_valid = 1'b0;
        wait_done(lat, bcyc);
        checks++;
        if (dut.in_r !== 8'h02 || bus.acc !== 20'h0000A) begin
            failures++; $display("FAIL busy_load_ignored in_r=%h acc=%h, required 02/0000a", dut.in_r, bus.acc);
        end
        tick();
    endtask

    task automatic test_idx_range();
        bus12.in_op = 3'b000; bus12.in_idx = 2'd3; bus12.in_nib = 4'hF; bus12.in_valid = 1'b1;
        #1;
        checks++;
        if (bus12.in_ready !== 1'b1) begin
            failures++; $display("FAIL idx_oob_ready got %b, required 1", bus12.in_ready);
        end
        tick();
        checks++;
        if (dut12.in_r !== 12'h000 || dut12.wgt_r !== 12'h000) begin
            failures++; $display("FAIL idx_oob in_r=%h wgt_r=%h, required 000/000", dut12.in_r, dut12.wgt_r);
        end
        bus12.in_idx = 2'd2; bus12.in_nib = 4'h7;
        tick();
        bus12.in_valid = 1'b0;
        checks++;
        if (dut12.in_r !== 12'h700) begin
            failures++; $display("FAIL idx_top_nibble in_r=%h, required 700", dut12.in_r);
        end
    endtask

    task automatic test_zero_operand();
        int lat, bcyc;
        set_ops(8'h03, 8'h61);
        run(3'b010, lat, bcyc);
        checks++;
        if (bus.acc !== 20'h00123) begin
            failures++; $display("FAIL zero_setup acc=%h, required 00123", bus.acc);
        end
        set_ops(8'h00, 8'hFF);
        run(3'b011, lat, bcyc);
        checks++;
        if (lat !== 8 || bcyc !== 8 || bus.acc !== 20'h00123 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL zero_mac lat=%0d busy=%0d acc=%h ovf=%b, required 8/8/00123/0",
                     lat, bcyc, bus.acc, bus.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_idx_range();
        test_mul();
        test_clear_noop();
        test_mac_overflow();
        test_ena_stall();
        test_reset_abort();
        test_refuse_load();
        test_zero_operand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
